uart_cmd_rx: RTL and testbench
==============================

// Module: uart_cmd_rx
// PURPOSE
//  Serial command receiver for the Segway BLE link. Frames 8N1 bytes (e.g. 'G'=0x47, 'S'=0x53)
//  arriving on the RX pin, driven by the BLE module or the bench UART_tx. Hands each byte to
//  the authorization logic with a rdy/clr_rdy handshake and flags bad stop bits.
// PARAMETERS
//  BAUD_CYCLES  2604  clk cycles per bit (50 MHz / 19200 baud)
//  HALF_CYCLES  1302  clk cycles from start-bit edge to mid start bit (BAUD_CYCLES/2)
// PORTS
//  clk      in   1  system clock, 50 MHz
//  rst_n    in   1  asynchronous active-low reset
//  RX       in   1  serial line, idles high, asynchronous to clk
//  clr_rdy  in   1  consumer acknowledge; clears rdy
//  rx_data  out  8  last good received byte, LSB first on the line
//  rdy      out  1  new byte valid in rx_data
//  frm_err  out  1  last frame had stop bit = 0 (sticky until next start bit or reset)
// BEHAVIOUR
//  - Reset values:
//    - rx_data=8'h00, rdy=0, frm_err=0, state=IDLE.
//    - Both RX synchronizer flops preset to 1 so reset never produces a false start.
//  - RX is double-flopped (RX_s). All decisions use RX_s, so line-to-detect latency is 2 clks.
//  - States:
//    - IDLE:
//      - RX_s==0 -> START.
//      - Load baud_cnt=HALF_CYCLES, bit_cnt=0.
//      - Clear rdy and frm_err.
//    - START:
//      - baud_cnt counts down to 0, then sample RX_s.
//      - Sample 1 -> glitch: return to IDLE, no output change.
//      - Sample 0 -> DATA, reload baud_cnt=BAUD_CYCLES.
//    - DATA:
//      - At each baud_cnt==0, shift RX_s into shift_reg MSB (right shift) and bit_cnt++.
//      - Reload baud_cnt=BAUD_CYCLES on every shift.
//      - bit_cnt==8 -> STOP.
//    - STOP:
//      - At baud_cnt==0, sample RX_s.
//      - Sample 1 -> rx_data<=shift_reg, rdy<=1, frm_err<=0.
//      - Sample 0 -> frm_err<=1, rdy stays 0, rx_data unchanged.
//      - Either way -> IDLE. The frame never waits for full stop-bit end.
//  - Latency: rdy rises HALF_CYCLES + 9*BAUD_CYCLES = 24738 (+2 sync, +1 reg) clks after RX falls.
//  - baud_cnt is 12 bits wide. bit_cnt is 4 bits wide and saturates at 8. No wrap in any mode.
//  - Handshake:
//    - rdy is set only in STOP.
//    - rdy clears on clr_rdy==1, or when IDLE detects a new start bit.
//    - clr_rdy in the same cycle as the STOP set: the set wins, rdy=1.
//  - Back-to-back bytes without clr_rdy: rx_data is overwritten and rdy re-asserts (drops for the frame).
//  - clr_rdy while not rdy: no effect. clr_rdy never disturbs an in-progress frame.
//  - Reset mid-frame: immediate return to IDLE with reset values. The next full frame is received normally.
//  - RX low at reset release: treated as start edge only after it has been seen through the synchronizer.
// TESTING
//  1. UART_tx sends 0x47 -> rdy=1 at 24741+/-3 clks after TX start edge, rx_data=0x47, frm_err=0.
//  2. Pulse clr_rdy after test 1 -> rdy=0 next clk, rx_data holds 0x47. Repeat with clr_rdy coincident with STOP sample -> rdy=1.
//  3. Send 0x53 then 0x47 back-to-back, no clr_rdy -> rdy re-asserts twice, final rx_data=0x47.
//  4. Drive RX low for 500 clks then high -> no rdy, frm_err=0, next 0xAA frame received correctly.
//  5. Hand-drive frame 0x5A with stop bit 0 -> frm_err=1, rdy=0, rx_data unchanged. A following good 0x47 clears frm_err, rdy=1.
//  6. Assert rst_n low at bit 4 of a 0x47 frame -> outputs reset same cycle. Following 0x53 gives rx_data=0x53, rdy=1.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// 8N1 serial byte receiver: synchronizes RX, frames start/data/stop bits and hands
// each good byte over with a rdy/clr_rdy handshake; a zero stop bit raises frm_err.
`timescale 1ns/1ps
module uart_cmd_rx #(
    parameter int unsigned BAUD_CYCLES = 2604,
    parameter int unsigned HALF_CYCLES = BAUD_CYCLES / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);
    localparam logic [11:0] BAUD_LD = 12'(BAUD_CYCLES);
    localparam logic [11:0] HALF_LD = 12'(HALF_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  rx_sync_q;
    logic        rx_s;
    logic [11:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rdy_q, rdy_d;
    logic        frm_err_q, frm_err_d;
    logic        baud_tick_s;

    assign rx_s = rx_sync_q[1];
    // The interval ends on the clock where the counter would hit zero, so each one lasts exactly the loaded count.
    assign baud_tick_s = (baud_cnt_q <= 12'd1);

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;

    // Two-flop synchronizer for the asynchronous RX line, preset to idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], RX};
        end
    end

    // Frame state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= 12'd0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rdy_q      <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            frm_err_q  <= frm_err_d;
        end
    end

    // Next-state and output logic; a STOP-time set of rdy overrides a coincident clr_rdy.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rdy_d      = rdy_q;
        frm_err_d  = frm_err_q;

        if (clr_rdy) begin
            rdy_d = 1'b0;
        end else begin
            rdy_d = rdy_q;
        end

        case (state_q)
            IDLE: begin
                baud_cnt_d = HALF_LD;
                bit_cnt_d  = 4'd0;
                if (!rx_s) begin
                    state_d   = START;
                    rdy_d     = 1'b0;
                    frm_err_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_tick_s) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DATA;
                        baud_cnt_d = BAUD_LD;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 12'd1;
                end
            end
            DATA: begin
                if (baud_tick_s) begin
                    shift_d    = {rx_s, shift_q[7:1]};
                    baud_cnt_d = BAUD_LD;
                    bit_cnt_d  = (bit_cnt_q < 4'd8) ? (bit_cnt_q + 4'd1) : bit_cnt_q;
                    if (bit_cnt_q >= 4'd7) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 12'd1;
                end
            end
            STOP: begin
                if (baud_tick_s) begin
                    state_d = IDLE;
                    if (rx_s) begin
                        rx_data_d = shift_q;
                        rdy_d     = 1'b1;
                        frm_err_d = 1'b0;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 12'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomized bench for uart_cmd_rx: frames are scheduled as timed events from the
// line-to-output latency rule and compared against the DUT on every cycle.
`timescale 1ns/1ps
module tb_uart_cmd_rx;
    localparam int BAUD     = 16;
    localparam int HALF     = 8;
    localparam int DONE_OFS = 3 + HALF + 9 * BAUD;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       RX = 1'b1;
    logic       clr_dir = 1'b0;
    logic       clr_rnd = 1'b0;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    ev_t        evq[$];
    int         cyc = 0;
    int         t0 = 0;
    int         total = 0;
    int         bad = 0;
    int         rises = 0;
    int         rise_cyc = 0;
    bit         chk_en = 1'b0;
    bit         rand_clr = 1'b0;
    logic       prev_rdy = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_rdy = 1'b0;
    logic       exp_frm = 1'b0;

    assign clr_rdy = clr_dir | clr_rnd;

    uart_cmd_rx #(.BAUD_CYCLES(BAUD), .HALF_CYCLES(HALF)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy),
        .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    // Reference model: applies scheduled frame events and clr_rdy at each clock edge.
    always @(posedge clk) begin : model
        bit         det;
        bit         good;
        bit         badst;
        logic [7:0] gb;
        ev_t        e;
        det = 1'b0; good = 1'b0; badst = 1'b0; gb = 8'h00;
        cyc = cyc + 1;
        if (rst_n) begin
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                e = evq.pop_front();
                if (e.cyc == cyc) begin
                    if (e.kind == 0) det = 1'b1;
                    else if (e.kind == 1) begin good = 1'b1; gb = e.b; end
                    else badst = 1'b1;
                end
            end
            if (good) begin
                exp_rdy = 1'b1; exp_data = gb; exp_frm = 1'b0;
            end else begin
                if (clr_rdy || det) exp_rdy = 1'b0;
                if (det) exp_frm = 1'b0;
                if (badst) exp_frm = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("rx_data", 32'(rx_data), 32'(exp_data));
            chk("rdy", 32'(rdy), 32'(exp_rdy));
            chk("frm_err", 32'(frm_err), 32'(exp_frm));
            if (rdy && !prev_rdy) begin
                rises++;
                rise_cyc = cyc;
            end
        end
        prev_rdy = rdy;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            clr_rnd = rand_clr && ($urandom_range(0, 7) == 0);
        end
    end

    task automatic drive_frame(input logic [7:0] b, input bit stop_ok, input int nbits);
        ev_t e;
        @(posedge clk);
        #1;
        RX = 1'b0;
        t0 = cyc;
        e.cyc = t0 + 3; e.kind = 0; e.b = 8'h00;
        evq.push_back(e);
        if (nbits == 8) begin
            e.cyc = t0 + DONE_OFS; e.kind = stop_ok ? 1 : 2; e.b = b;
            evq.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            repeat (BAUD) @(posedge clk);
            #1;
            RX = b[i];
        end
        if (nbits == 8) begin
            repeat (BAUD) @(posedge clk);
            #1;
            if (stop_ok) begin
                RX = 1'b1;
                repeat (BAUD) @(posedge clk);
                #1;
            end else begin
                // Zero only across the sample point so the receiver sees idle once it returns.
                RX = 1'b0;
                repeat (HALF + 1) @(posedge clk);
                #1;
                RX = 1'b1;
                repeat (BAUD - HALF - 1) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_glitch(input int len);
        ev_t e;
        @(posedge clk);
        #1;
        RX = 1'b0;
        t0 = cyc;
        e.cyc = t0 + 3; e.kind = 0; e.b = 8'h00;
        evq.push_back(e);
        repeat (len) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (BAUD - len) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        evq.delete();
        exp_data = 8'h00; exp_rdy = 1'b0; exp_frm = 1'b0;
        RX = 1'b1;
        #1;
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_rdy", 32'(rdy), 32'h0);
        chk("rst_frm_err", 32'(frm_err), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();
        chk_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        rises = 0;
        drive_frame(8'h47, 1'b1, 8);
        chk("t1_latency", 32'(rise_cyc - t0), 32'd155);
        chk("t1_data", 32'(rx_data), 32'h47);
        chk("t1_rdy", 32'(rdy), 32'h1);

        @(posedge clk); #1; clr_dir = 1'b1;
        @(posedge clk); #1; clr_dir = 1'b0;
        chk("t2_clr_rdy", 32'(rdy), 32'h0);
        chk("t2_hold_data", 32'(rx_data), 32'h47);

        fork
            drive_frame(8'h47, 1'b1, 8);
            begin
                @(posedge clk);
                #2;
                while (cyc < t0 + DONE_OFS - 1) begin
                    @(posedge clk);
                    #1;
                end
                clr_dir = 1'b1;
                @(posedge clk);
                #1;
                clr_dir = 1'b0;
            end
        join
        chk("t2_set_wins", 32'(rdy), 32'h1);

        rises = 0;
        drive_frame(8'h53, 1'b1, 8);
        drive_frame(8'h47, 1'b1, 8);
        chk("t3_rises", 32'(rises), 32'd2);
        chk("t3_data", 32'(rx_data), 32'h47);

        send_glitch(4);
        chk("t4_glitch_rdy", 32'(rdy), 32'h0);
        chk("t4_glitch_frm", 32'(frm_err), 32'h0);
        drive_frame(8'hAA, 1'b1, 8);
        chk("t4_data", 32'(rx_data), 32'hAA);

        drive_frame(8'h5A, 1'b0, 8);
        chk("t5_frm_err", 32'(frm_err), 32'h1);
        chk("t5_rdy", 32'(rdy), 32'h0);
        chk("t5_data_kept", 32'(rx_data), 32'hAA);
        drive_frame(8'h47, 1'b1, 8);
        chk("t5_frm_clear", 32'(frm_err), 32'h0);
        chk("t5_rdy_good", 32'(rdy), 32'h1);

        drive_frame(8'h47, 1'b1, 5);
        do_reset();
        drive_frame(8'h53, 1'b1, 8);
        chk("t6_data", 32'(rx_data), 32'h53);
        chk("t6_rdy", 32'(rdy), 32'h1);

        rand_clr = 1'b1;
        for (int n = 0; n < 120; n++) begin
            int kind;
            kind = $urandom_range(0, 19);
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
            if (kind <= 13) drive_frame(8'($urandom), 1'b1, 8);
            else if (kind <= 16) drive_frame(8'($urandom), 1'b0, 8);
            else if (kind <= 18) send_glitch($urandom_range(1, HALF - 1));
            else begin
                drive_frame(8'($urandom), 1'b1, $urandom_range(1, 7));
                do_reset();
            end
        end
        rand_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end
endmodule
